// File: rtl/envelope_multi_if.sv
// rtl/envelope_multi_if.sv - envelope_multi control/level bundle (done only with ENVELOPE_DONE_PULSE_EN)
interface envelope_multi_if #(
    parameter int CHANNELS      = 3,
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
);
    logic                              clk_en;
    logic [CHANNELS*PERIOD_BITS-1:0]   period;
    logic [CHANNELS*4-1:0]             shape;
    logic [CHANNELS-1:0]               shape_wr;
    logic [CHANNELS*ENVELOPE_BITS-1:0] out;
    logic [CHANNELS-1:0]               holding;
`ifdef ENVELOPE_DONE_PULSE_EN
    logic [CHANNELS-1:0]               done;
`endif

    modport master (
        output clk_en,
        output period,
        output shape,
        output shape_wr,
`ifdef ENVELOPE_DONE_PULSE_EN
        input  done,
`endif
        input  out,
        input  holding
    );

    modport slave (
        input  clk_en,
        input  period,
        input  shape,
        input  shape_wr,
`ifdef ENVELOPE_DONE_PULSE_EN
        output done,
`endif
        output out,
        output holding
    );
endinterface

// File: rtl/envelope_multi.sv
// rtl/envelope_multi.sv - multi-channel clock-enabled envelope generator (optional done pulse: ENVELOPE_DONE_PULSE_EN)
module envelope_multi #(
    parameter int CHANNELS      = 3,
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    envelope_multi_if.slave   bus
);
    localparam logic [ENVELOPE_BITS-1:0] MAX   = '1;
    localparam logic [ENVELOPE_BITS-1:0] ONE_E = {{(ENVELOPE_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_BITS-1:0]   ONE_P = {{(PERIOD_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t                   state_q, state_d;
        logic [PERIOD_BITS-1:0]   pcnt_q, pcnt_d;
        logic [ENVELOPE_BITS-1:0] cnt_q, cnt_d;
        logic [ENVELOPE_BITS-1:0] held_q, held_d;
        logic [ENVELOPE_BITS-1:0] out_q, out_d;
        logic [3:0]               shape_q, shape_d;
        logic                     invert_q, invert_d;
        logic                     holding_q;
        logic [PERIOD_BITS-1:0]   per_i;
        logic [PERIOD_BITS-1:0]   last_i;
        logic                     cont, att, alt, hld, hold_e;
`ifdef ENVELOPE_DONE_PULSE_EN
        logic                     seg_end;
        logic                     done_q;
`endif

        assign per_i  = bus.period[i*PERIOD_BITS +: PERIOD_BITS];
        // A zero period behaves like one, so the last count index is clamped at 0.
        assign last_i = (per_i == '0) ? '0 : per_i - ONE_P;
        assign cont   = shape_q[3];
        assign att    = shape_q[2];
        assign alt    = shape_q[1];
        assign hld    = shape_q[0];
        assign hold_e = hld | ~cont;

        // Next-state: restart strobe wins over a step; level is derived from the next state.
        always_comb begin
            state_d  = state_q;
            pcnt_d   = pcnt_q;
            cnt_d    = cnt_q;
            held_d   = held_q;
            shape_d  = shape_q;
            invert_d = invert_q;
`ifdef ENVELOPE_DONE_PULSE_EN
            seg_end  = 1'b0;
`endif
            if (bus.shape_wr[i]) begin
                shape_d  = bus.shape[i*4 +: 4];
                cnt_d    = '0;
                pcnt_d   = '0;
                invert_d = ~bus.shape[i*4 + 2];
                state_d  = ST_RUN;
            end else if (bus.clk_en && state_q == ST_RUN) begin
                if (pcnt_q >= last_i) begin
                    pcnt_d = '0;
                    if (cnt_q != MAX) begin
                        cnt_d = cnt_q + ONE_E;
                    end else if (hold_e) begin
                        state_d = ST_HOLD;
                        held_d  = (cont & hld & (att ^ alt)) ? MAX : '0;
`ifdef ENVELOPE_DONE_PULSE_EN
                        seg_end = 1'b1;
`endif
                    end else begin
                        cnt_d    = '0;
                        invert_d = invert_q ^ alt;
`ifdef ENVELOPE_DONE_PULSE_EN
                        seg_end  = 1'b1;
`endif
                    end
                end else begin
                    pcnt_d = pcnt_q + ONE_P;
                end
            end
            out_d = (state_d == ST_RUN) ? (invert_d ? MAX - cnt_d : cnt_d) : held_d;
        end

        // State and registered outputs; reset parks the channel in HOLD at level 0.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q   <= ST_HOLD;
                pcnt_q    <= '0;
                cnt_q     <= '0;
                held_q    <= '0;
                shape_q   <= '0;
                invert_q  <= 1'b0;
                out_q     <= '0;
                holding_q <= 1'b1;
`ifdef ENVELOPE_DONE_PULSE_EN
                done_q    <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                pcnt_q    <= pcnt_d;
                cnt_q     <= cnt_d;
                held_q    <= held_d;
                shape_q   <= shape_d;
                invert_q  <= invert_d;
                out_q     <= out_d;
                holding_q <= (state_d == ST_HOLD);
`ifdef ENVELOPE_DONE_PULSE_EN
                done_q    <= seg_end;
`endif
            end
        end

        assign bus.out[i*ENVELOPE_BITS +: ENVELOPE_BITS] = out_q;
        assign bus.holding[i] = holding_q;
`ifdef ENVELOPE_DONE_PULSE_EN
        assign bus.done[i] = done_q;
`endif
    end
endmodule

// File: tb/tb_envelope_multi.sv
// tb/tb_envelope_multi.sv - randomized/directed checks of envelope_multi against a shape-rule model
module tb_envelope_multi;
    localparam int CH   = 3;
    localparam int PB   = 16;
    localparam int EB   = 4;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    envelope_multi_if #(.CHANNELS(CH), .PERIOD_BITS(PB), .ENVELOPE_BITS(EB)) bus ();
    envelope_multi #(.CHANNELS(CH), .PERIOD_BITS(PB), .ENVELOPE_BITS(EB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_asserts = 0;
    int n_fail = 0;

    // Model: per channel, steps since restart = enabled cycles / effective period.
    logic       m_act [CH];
    logic [3:0] m_s   [CH];
    int         m_p   [CH];
    int         m_n   [CH];
    logic       m_done[CH];

    function automatic int lvl(input logic [3:0] s, input int k);
        logic cont, att, alt, hld;
        int seg, pos;
        logic dir;
        cont = s[3]; att = s[2]; alt = s[1]; hld = s[0];
        if (k <= MAXV) return att ? k : MAXV - k;
        if (hld | ~cont) return (cont & hld & (att ^ alt)) ? MAXV : 0;
        seg = k / (MAXV + 1);
        pos = k % (MAXV + 1);
        dir = att ^ (alt & seg[0]);
        return dir ? pos : MAXV - pos;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_asserts++;
        assert (obs === 32'(expv)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_ch(input int c, input logic [3:0] s, input logic [15:0] p);
        bus.shape[c*4 +: 4]   = s;
        bus.period[c*PB +: PB] = p;
    endtask

    task automatic check_ch(input int c);
        int k;
        logic he;
        k  = m_act[c] ? m_n[c] / m_p[c] : 0;
        he = m_s[c][0] | ~m_s[c][3];
        chk($sformatf("out%0d", c), 32'(bus.out[c*EB +: EB]), m_act[c] ? lvl(m_s[c], k) : 0);
        chk($sformatf("holding%0d", c), 32'(bus.holding[c]), m_act[c] ? int'(he && k > MAXV) : 1);
`ifdef ENVELOPE_DONE_PULSE_EN
        chk($sformatf("done%0d", c), 32'(bus.done[c]), int'(m_done[c]));
`endif
    endtask

    task automatic tick(input logic [2:0] wr, input logic en, input logic [2:0] chkm);
        int k_old, k_new;
        logic he;
        bus.shape_wr = wr;
        bus.clk_en   = en;
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            k_old = m_act[c] ? m_n[c] / m_p[c] : 0;
            m_done[c] = 1'b0;
            if (wr[c]) begin
                m_act[c] = 1'b1;
                m_n[c]   = 0;
                m_s[c]   = bus.shape[c*4 +: 4];
                m_p[c]   = (bus.period[c*PB +: PB] == 0) ? 1 : int'(bus.period[c*PB +: PB]);
            end else if (m_act[c] && en) begin
                m_n[c]++;
                k_new = m_n[c] / m_p[c];
                he = m_s[c][0] | ~m_s[c][3];
                m_done[c] = (k_new != k_old) && (k_new % (MAXV + 1) == 0) &&
                            (!he || k_new == MAXV + 1);
            end
            if (chkm[c]) check_ch(c);
        end
        bus.shape_wr = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 1'b0; m_n[c] = 0; m_p[c] = 1; m_s[c] = '0; m_done[c] = 1'b0;
            check_ch(c);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] wr;
        logic [3:0] s;
        bus.clk_en   = 1'b1;
        bus.period   = '0;
        bus.shape    = '0;
        bus.shape_wr = '0;
        // Reset state, with a strobe and enable asserted to show reset overrides them.
        bus.shape_wr = 3'b111;
        do_reset();
        bus.shape_wr = '0;
        do_reset();

        // Idle: nothing started, enabled clock must not step anything.
        for (int i = 0; i < 20; i++) tick(3'b000, 1'b1, 3'b111);

        // Ch0 single decay with period 2.
        set_ch(0, 4'b0000, 16'd2);
        tick(3'b001, 1'b1, 3'b111);
        for (int i = 0; i < 40; i++) tick(3'b000, 1'b1, 3'b111);

        // Ch1 continuous triangle with period 1.
        set_ch(1, 4'b1010, 16'd1);
        tick(3'b010, 1'b1, 3'b111);
        for (int i = 0; i < 40; i++) tick(3'b000, 1'b1, 3'b111);

        // Ch2 with period 0: decay-then-hold-high, then attack-then-hold.
        set_ch(2, 4'b1011, 16'd0);
        tick(3'b100, 1'b1, 3'b111);
        for (int i = 0; i < 20; i++) tick(3'b000, 1'b1, 3'b111);
        set_ch(2, 4'b1101, 16'd0);
        tick(3'b100, 1'b1, 3'b111);
        for (int i = 0; i < 20; i++) tick(3'b000, 1'b1, 3'b111);

        // Restart collides with a due step: ch0 at cnt 7 with a step due.
        set_ch(0, 4'b1100, 16'd2);
        tick(3'b001, 1'b1, 3'b111);
        for (int i = 0; i < 15; i++) tick(3'b000, 1'b1, 3'b111);
        chk("collide_pre", 32'(bus.out[3:0]), 7);
        set_ch(0, 4'b1000, 16'd2);
        tick(3'b001, 1'b1, 3'b111);
        chk("collide_post", 32'(bus.out[3:0]), 15);
        for (int i = 0; i < 4; i++) tick(3'b000, 1'b1, 3'b111);

        // Period 3 with a randomly gated enable.
        set_ch(0, 4'b1100, 16'd3);
        tick(3'b001, 1'b1, 3'b111);
        for (int i = 0; i < 60; i++) tick(3'b000, 1'($urandom_range(0, 1)), 3'b111);

        // Simultaneous strobes on all channels.
        set_ch(0, 4'b1110, 16'd1);
        set_ch(1, 4'b0100, 16'd2);
        set_ch(2, 4'b1000, 16'd0);
        tick(3'b111, 1'b1, 3'b111);
        for (int i = 0; i < 30; i++) tick(3'b000, 1'b1, 3'b111);

        // Random restarts, shapes, periods, enables; shape input scrambled without strobe.
        for (int i = 0; i < 400; i++) begin
            wr = '0;
            for (int c = 0; c < CH; c++) begin
                s = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) begin
                    wr[c] = 1'b1;
                    set_ch(c, s, 16'($urandom_range(0, 3)));
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.shape[c*4 +: 4] = s;
                end
            end
            tick(wr, 1'($urandom_range(0, 3) != 0), 3'b111);
        end

        // Period lowered below the running count steps on the next enabled cycle.
        set_ch(0, 4'b1100, 16'd8);
        tick(3'b001, 1'b1, 3'b111);
        for (int i = 0; i < 5; i++) tick(3'b000, 1'b1, 3'b110);
        chk("shrink_pre", 32'(bus.out[3:0]), 0);
        bus.period[15:0] = 16'd2;
        tick(3'b000, 1'b1, 3'b110);
        chk("shrink_step", 32'(bus.out[3:0]), 1);
        tick(3'b000, 1'b1, 3'b110);
        chk("shrink_wait", 32'(bus.out[3:0]), 1);
        tick(3'b000, 1'b1, 3'b110);
        chk("shrink_next", 32'(bus.out[3:0]), 2);

        // Reset in the middle of running ramps.
        set_ch(0, 4'b1100, 16'd1);
        set_ch(1, 4'b1010, 16'd2);
        set_ch(2, 4'b1110, 16'd0);
        tick(3'b111, 1'b1, 3'b111);
        for (int i = 0; i < 10; i++) tick(3'b000, 1'b1, 3'b111);
        do_reset();
        tick(3'b000, 1'b1, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
